hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's fixed forward/load-use hazard logic.
- Tracks in-flight register writes with per-register latency countdowns, so producers of any latency up to MAX_LAT can coexist: ALU 1, load 2, multi-cycle mul/div up to MAX_LAT.
- Sits beside ID/EX issue; raises a stall until every source operand of the instruction in ID is forwardable, and keeps a saturating stall-cycle statistic.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/sb_counter.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared constants for the hazard scoreboard and its users.
//   - Default register-file geometry (NREG_DEF, AW_DEF) and maximum latency.
//   - Producer latencies as seen by the scoreboard. An ALU result is covered
//     by forwarding, so it reserves nothing. Longer producers reserve their
//     destination for the given number of cycles.
//   - ZERO_REG is the hard-wired zero register, which is never tracked.
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int NREG_DEF    = 32;
    localparam int AW_DEF      = 5;
    localparam int MAX_LAT_DEF = 7;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = MAX_LAT_DEF;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/sb_counter.sv
// ---------------------------------------------------------------------------
// sb_counter
// Latency countdown for one architectural register.
// The count falls by one each cycle until it reaches zero. A reservation
// loads the larger of the decremented count and the requested latency. The
// requested latency is first clipped to MAX_LAT.
// Ports:
//   clk        clock
//   rst_async  asynchronous active-high reset, clears the countdown
//   reserve    an issuing instruction writes this register this cycle
//   lat        requested latency of that producer (0 = no reservation)
//   busy       countdown is non-zero, so the value is not yet forwardable
// ---------------------------------------------------------------------------
module sb_counter #(
    parameter int CW      = 3,
    parameter int MAX_LAT = 7
) (
    input  logic          clk,
    input  logic          rst_async,
    input  logic          reserve,
    input  logic [CW-1:0] lat,
    output logic          busy
);

    localparam logic [CW-1:0] LAT_CAP = CW'(MAX_LAT);

    logic [CW-1:0] cnt;
    logic [CW-1:0] dec;
    logic [CW-1:0] lat_eff;
    logic [CW-1:0] cnt_next;

    // Taking the max keeps the register busy until the slowest of two
    // overlapping writers (WAW) is ready. A zero latency therefore leaves
    // the countdown untouched.
    always_comb begin
        dec      = (cnt != '0) ? (cnt - CW'(1)) : '0;
        lat_eff  = (lat > LAT_CAP) ? LAT_CAP : lat;
        cnt_next = dec;
        if (reserve && (lat_eff > dec)) begin
            cnt_next = lat_eff;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Sits beside ID/EX issue and tracks in-flight register writes with one
// countdown per register. It stalls the instruction in ID until every source
// operand it reads is forwardable. It also counts stalled cycles in a
// saturating statistic.
// Ports:
//   clk, rst_async  clock and asynchronous active-high reset
//   src_valid       per-source "operand is read" flags of the ID instruction
//   src_addr        packed source addresses; source i in [i*AW +: AW]
//   issue_valid     ID instruction requests to issue
//   issue_we        it writes a destination register
//   issue_rd        its destination register
//   issue_lat       cycles until its result is forwardable (0 = none)
//   flush           kill this cycle's issue (no reservation is made)
//   stall           hold PC/IF/ID and bubble EX
//   busy            per-register "reservation outstanding" flags
//   stall_count     saturating count of cycles with stall = 1
//   clr_stats       synchronous clear of stall_count (wins over increment)
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int AW      = AW_DEF,
    parameter int NSRC    = 2,
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int CW      = 3,
    parameter int SW      = 16
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic [NSRC-1:0]  src_valid,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [AW-1:0]    issue_rd,
    input  logic [CW-1:0]    issue_lat,
    input  logic             flush,
    output logic             stall,
    output logic [NREG-1:0]  busy,
    output logic [SW-1:0]    stall_count,
    input  logic             clr_stats
);

    logic issue_fire;

    // A source stalls only while its producer's countdown is non-zero.
    // Reads see the countdowns from before this cycle's update, so an
    // instruction never stalls on its own reservation.
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i] &&
                (src_addr[i*AW +: AW] != AW'(ZERO_REG)) &&
                busy[src_addr[i*AW +: AW]]) begin
                stall = 1'b1;
            end
        end
    end

    assign issue_fire = issue_valid && !stall && !flush;

    // Register 0 is hard-wired zero and never tracked.
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic reserve;

        assign reserve = issue_fire && issue_we && (issue_rd == AW'(r));

        sb_counter #(
            .CW      (CW),
            .MAX_LAT (MAX_LAT)
        ) u_cnt (
            .clk       (clk),
            .rst_async (rst_async),
            .reserve   (reserve),
            .lat       (issue_lat),
            .busy      (busy[r])
        );
    end

    // Stall statistic: the clear has priority, and the count holds at all-ones.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            stall_count <= '0;
        end else if (clr_stats) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {SW{1'b1}})) begin
            stall_count <= stall_count + SW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard. The reference model records, for
// each register, the absolute cycle number at which its value becomes
// forwardable. Literal checks at the key points of each scenario pin that
// model to hand-derived values.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int NSRC    = 2;
    localparam int MAX_LAT = 7;
    localparam int CW      = 4;
    localparam int SW      = 4;
    localparam int SMAX    = (1 << SW) - 1;

    logic              clk;
    logic              rst_async;
    logic [NSRC-1:0]   src_valid;
    logic [NSRC*AW-1:0] src_addr;
    logic              issue_valid;
    logic              issue_we;
    logic [AW-1:0]     issue_rd;
    logic [CW-1:0]     issue_lat;
    logic              flush;
    logic              stall;
    logic [NREG-1:0]   busy;
    logic [SW-1:0]     stall_count;
    logic              clr_stats;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(
        .NREG(NREG), .AW(AW), .NSRC(NSRC), .MAX_LAT(MAX_LAT), .CW(CW), .SW(SW)
    ) dut (
        .clk         (clk),
        .rst_async   (rst_async),
        .src_valid   (src_valid),
        .src_addr    (src_addr),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_rd    (issue_rd),
        .issue_lat   (issue_lat),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .stall_count (stall_count),
        .clr_stats   (clr_stats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: ready[r] is the first cycle in which register r may be consumed.
    int ready [NREG];
    int cyc   = 0;
    int mstat = 0;

    function automatic bit m_busy(int r);
        return (r != 0) && (cyc < ready[r]);
    endfunction

    function automatic bit m_stall();
        bit s = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_valid[i] && m_busy(int'(src_addr[i*AW +: AW]))) s = 1'b1;
        end
        return s;
    endfunction

    always @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            for (int r = 0; r < NREG; r++) ready[r] = 0;
            mstat = 0;
        end else begin
            bit st;
            int l;
            st = m_stall();
            if (issue_valid && !st && !flush && issue_we && issue_rd != 0) begin
                l = (int'(issue_lat) > MAX_LAT) ? MAX_LAT : int'(issue_lat);
                if (cyc + l + 1 > ready[issue_rd]) ready[issue_rd] = cyc + l + 1;
            end
            if (clr_stats) mstat = 0;
            else if (st && mstat < SMAX) mstat = mstat + 1;
            cyc = cyc + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle outside reset, the outputs are compared against the model.
    always @(negedge clk) begin
        if (!rst_async) begin
            logic [NREG-1:0] exp_busy;
            for (int r = 0; r < NREG; r++) exp_busy[r] = m_busy(r);
            checkOutput("model_stall", 64'(stall), 64'(m_stall()));
            checkOutput("model_busy", 64'(busy), 64'(exp_busy));
            checkOutput("model_stall_count", 64'(stall_count), 64'(mstat));
        end
    end

    task automatic applyStimulus(input logic [1:0] sv, input int a0, input int a1,
                                 input logic iv, input logic we, input int rd,
                                 input int lat, input logic fl, input logic clr);
        src_valid   = sv;
        src_addr    = {AW'(a1), AW'(a0)};
        issue_valid = iv;
        issue_we    = we;
        issue_rd    = AW'(rd);
        issue_lat   = CW'(lat);
        flush       = fl;
        clr_stats   = clr;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats();
        applyStimulus(2'b00, 0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        nextCycle();
    endtask

    initial begin
        rst_async = 1'b0;
        idle();
        #1 rst_async = 1'b1;
        #11;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_stall_count", 64'(stall_count), 64'd0);
        rst_async = 1'b0;
        nextCycle();

        // Load-use: producer in T0, consumer stalls in T1 only.
        clearStats();
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 4, LAT_LOAD, 1'b0, 1'b0);
        #2 checkOutput("loaduse_t0_stall", 64'(stall), 64'd0);
        nextCycle();
        applyStimulus(2'b01, 4, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        #2 checkOutput("loaduse_t1_stall", 64'(stall), 64'd1);
        nextCycle();
        #2 checkOutput("loaduse_t2_stall", 64'(stall), 64'd0);
        nextCycle();
        idle();
        #2 checkOutput("loaduse_count", 64'(stall_count), 64'd1);
        nextCycle();

        // Long latency: mul with 3 cycles blocks the consumer 3 cycles.
        clearStats();
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 7, LAT_MUL, 1'b0, 1'b0);
        nextCycle();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(2'b10, 0, 7, 1'b1, 1'b1, 8, LAT_ALU, 1'b0, 1'b0);
            #2 checkOutput("mul_stall", 64'(stall), 64'(k <= 3));
            nextCycle();
        end
        idle();
        #2 checkOutput("mul_count", 64'(stall_count), 64'd3);
        nextCycle();

        // WAW: lat 5 then lat 1 on r9; the longer one decides.
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 9, 5, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 9, 1, 1'b0, 1'b0);
        #2 checkOutput("waw_busy_t1", 64'(busy[9]), 64'd1);
        nextCycle();
        idle();
        for (int k = 2; k <= 6; k++) begin
            #2 checkOutput("waw_busy", 64'(busy[9]), 64'(k <= 5));
            nextCycle();
        end

        // Zero register, flush and r0 reads.
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 0, 5, 1'b0, 1'b0);
        nextCycle();
        idle();
        #2 checkOutput("zero_rd_busy", 64'(busy), 64'd0);
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 2, 3, 1'b1, 1'b0);
        nextCycle();
        idle();
        #2 checkOutput("flush_busy2", 64'(busy[2]), 64'd0);
        applyStimulus(2'b11, 0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        #2 checkOutput("r0_no_stall", 64'(stall), 64'd0);
        nextCycle();

        // An existing countdown keeps running through a flushed, stalled cycle.
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 11, 2, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(2'b01, 11, 0, 1'b1, 1'b1, 11, 7, 1'b1, 1'b0);
        #2 checkOutput("flush_stall", 64'(stall), 64'd1);
        nextCycle();
        #2 checkOutput("flush_busy11_t2", 64'(busy[11]), 64'd1);
        nextCycle();
        idle();
        #2 checkOutput("flush_busy11_t3", 64'(busy[11]), 64'd0);
        nextCycle();

        // Self-dependence is not stalled by its own reservation.
        applyStimulus(2'b01, 5, 0, 1'b1, 1'b1, 5, 2, 1'b0, 1'b0);
        #2 checkOutput("selfdep_stall", 64'(stall), 64'd0);
        nextCycle();
        idle();
        #2 checkOutput("selfdep_busy", 64'(busy[5]), 64'd1);
        nextCycle();
        nextCycle();

        // Saturation: three 7-cycle stalls push the 4-bit count past 15.
        clearStats();
        for (int e = 0; e < 3; e++) begin
            applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 12, LAT_DIV, 1'b0, 1'b0);
            nextCycle();
            for (int k = 0; k < 8; k++) begin
                applyStimulus(2'b01, 12, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
                nextCycle();
            end
        end
        idle();
        #2 checkOutput("sat_count", 64'(stall_count), 64'(SMAX));
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 12, LAT_DIV, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(2'b01, 12, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
        #2 checkOutput("clr_with_stall", 64'(stall), 64'd1);
        nextCycle();
        applyStimulus(2'b01, 12, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        #2 checkOutput("clr_count", 64'(stall_count), 64'd0);
        nextCycle();
        idle();
        for (int k = 0; k < 7; k++) nextCycle();

        // Clip: latency 15 is clipped to 7.
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 10, 15, 1'b0, 1'b0);
        nextCycle();
        idle();
        for (int k = 1; k <= 8; k++) begin
            #2 checkOutput("clip_busy", 64'(busy[10]), 64'(k <= 7));
            nextCycle();
        end

        // Asynchronous reset in mid-countdown discards the reservation.
        applyStimulus(2'b00, 0, 0, 1'b1, 1'b1, 3, 3, 1'b0, 1'b0);
        nextCycle();
        idle();
        nextCycle();
        applyStimulus(2'b01, 3, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        #2 checkOutput("prereset_stall", 64'(stall), 64'd1);
        rst_async = 1'b1;
        #1;
        checkOutput("async_busy", 64'(busy), 64'd0);
        checkOutput("async_stall", 64'(stall), 64'd0);
        checkOutput("async_count", 64'(stall_count), 64'd0);
        #2 rst_async = 1'b0;
        nextCycle();
        #2 checkOutput("postreset_stall", 64'(stall), 64'd0);
        nextCycle();
        idle();
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
